// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, widths, wall bits and FSM states for the VGA box path
package vga_pkg;

   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;
   localparam int HALF_SIZE = 25;

   localparam int COORD_W = 10;
   localparam int VEL_W   = 8;
   localparam int POS_W   = 12;

   localparam int WALL_TOP    = 3;
   localparam int WALL_BOTTOM = 2;
   localparam int WALL_LEFT   = 1;
   localparam int WALL_RIGHT  = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_VEL,
      ST_POS,
      ST_CLAMP,
      ST_DONE
   } box_state_t;

endpackage

// File: rtl/box_motion_if.sv
// rtl/box_motion_if.sv - tilt/button inputs and box-centre outputs between display stage and box_motion
interface box_motion_if;
   import vga_pkg::*;

   logic                      frame_tick;
   logic signed [31:0]        accel_x;
   logic signed [31:0]        accel_y;
   logic                      BTNU;
   logic                      BTND;
   logic                      BTNL;
   logic                      BTNR;
   logic                      game_en;
   logic [COORD_W-1:0]        center_x;
   logic [COORD_W-1:0]        center_y;
   logic                      pos_valid;
   logic [3:0]                wall_hit;
   logic                      tick_overrun;

   modport master (
      output frame_tick, accel_x, accel_y, BTNU, BTND, BTNL, BTNR, game_en,
      input  center_x, center_y, pos_valid, wall_hit, tick_overrun
   );

   modport slave (
      input  frame_tick, accel_x, accel_y, BTNU, BTND, BTNL, BTNR, game_en,
      output center_x, center_y, pos_valid, wall_hit, tick_overrun
   );

endinterface

// File: rtl/box_motion_sat_signed.sv
// rtl/box_motion_sat_signed.sv - signed saturator: clamps din to [-LIMIT, +LIMIT] and narrows to OUT_W
module sat_signed #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 8,
   parameter int LIMIT = 8
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout
);

   localparam logic signed [IN_W-1:0]  IN_HI  = IN_W'(LIMIT);
   localparam logic signed [IN_W-1:0]  IN_LO  = -IN_HI;
   localparam logic signed [OUT_W-1:0] OUT_HI = OUT_W'(LIMIT);
   localparam logic signed [OUT_W-1:0] OUT_LO = -OUT_HI;

   always_comb begin
      dout = din[OUT_W-1:0];
      if (din > IN_HI)
         dout = OUT_HI;
      else if (din < IN_LO)
         dout = OUT_LO;
   end

endmodule

// File: rtl/box_motion.sv
// rtl/box_motion.sv - per-frame tilt/button velocity integration and clamped box-centre update
// Optional: define BOX_MOTION_BOUNCE_EN to reflect velocity at walls instead of zeroing it.
module box_motion
   import vga_pkg::*;
#(
   parameter int SCREEN_W    = vga_pkg::SCREEN_W,
   parameter int SCREEN_H    = vga_pkg::SCREEN_H,
   parameter int HALF_SIZE   = vga_pkg::HALF_SIZE,
   parameter int ACCEL_SHIFT = 6,
   parameter int VMAX        = 8
) (
   input logic           clk_25mHz,
   input logic           reset,
   box_motion_if.slave   bus
);

`ifdef BOX_MOTION_BOUNCE_EN
   localparam bit BOUNCE = 1'b1;
`else
   localparam bit BOUNCE = 1'b0;
`endif

   localparam logic signed [POS_W-1:0] X_MIN = POS_W'(HALF_SIZE);
   localparam logic signed [POS_W-1:0] X_MAX = POS_W'(SCREEN_W - 1 - HALF_SIZE);
   localparam logic signed [POS_W-1:0] Y_MIN = POS_W'(HALF_SIZE);
   localparam logic signed [POS_W-1:0] Y_MAX = POS_W'(SCREEN_H - 1 - HALF_SIZE);

   box_state_t                state;
   logic                      tick_q, tick_prev, tick_edge;
   logic signed [VEL_W-1:0]   ax_r, ay_r, vx, vy;
   logic signed [POS_W-1:0]   nx, ny;
   logic [COORD_W-1:0]        center_x, center_y;
   logic                      pos_valid, tick_overrun;
   logic [3:0]                wall_hit;

   logic signed [31:0]        shifted_x, shifted_y;
   logic signed [VEL_W-1:0]   tilt_x, tilt_y, btn_x, btn_y, vsat_x, vsat_y;
   logic signed [VEL_W+1:0]   sum_x, sum_y;
   logic [COORD_W-1:0]        cx_cl, cy_cl;
   logic signed [VEL_W-1:0]   vx_cl, vy_cl;
   logic [3:0]                wall_cl;

   assign tick_edge = tick_q & ~tick_prev;
   assign shifted_x = bus.accel_x >>> ACCEL_SHIFT;
   assign shifted_y = bus.accel_y >>> ACCEL_SHIFT;
   assign sum_x     = {{2{vx[VEL_W-1]}}, vx} + {{2{ax_r[VEL_W-1]}}, ax_r};
   assign sum_y     = {{2{vy[VEL_W-1]}}, vy} + {{2{ay_r[VEL_W-1]}}, ay_r};

   sat_signed #(.IN_W(32), .OUT_W(VEL_W), .LIMIT(VMAX)) u_tilt_x (.din(shifted_x), .dout(tilt_x));
   sat_signed #(.IN_W(32), .OUT_W(VEL_W), .LIMIT(VMAX)) u_tilt_y (.din(shifted_y), .dout(tilt_y));
   sat_signed #(.IN_W(VEL_W+2), .OUT_W(VEL_W), .LIMIT(VMAX)) u_vel_x (.din(sum_x), .dout(vsat_x));
   sat_signed #(.IN_W(VEL_W+2), .OUT_W(VEL_W), .LIMIT(VMAX)) u_vel_y (.din(sum_y), .dout(vsat_y));

   // Opposing buttons cancel; each contributes one px/frame of acceleration.
   always_comb begin
      btn_x = '0;
      btn_y = '0;
      case ({bus.BTNR, bus.BTNL})
         2'b10:   btn_x = VEL_W'(1);
         2'b01:   btn_x = {VEL_W{1'b1}};
         default: btn_x = '0;
      endcase
      case ({bus.BTND, bus.BTNU})
         2'b10:   btn_y = VEL_W'(1);
         2'b01:   btn_y = {VEL_W{1'b1}};
         default: btn_y = '0;
      endcase
   end

   always_comb begin
      cx_cl   = nx[COORD_W-1:0];
      cy_cl   = ny[COORD_W-1:0];
      vx_cl   = vx;
      vy_cl   = vy;
      wall_cl = '0;
      if (nx < X_MIN) begin
         cx_cl              = X_MIN[COORD_W-1:0];
         vx_cl              = BOUNCE ? -vx : '0;
         wall_cl[WALL_LEFT] = 1'b1;
      end else if (nx > X_MAX) begin
         cx_cl               = X_MAX[COORD_W-1:0];
         vx_cl               = BOUNCE ? -vx : '0;
         wall_cl[WALL_RIGHT] = 1'b1;
      end
      if (ny < Y_MIN) begin
         cy_cl             = Y_MIN[COORD_W-1:0];
         vy_cl             = BOUNCE ? -vy : '0;
         wall_cl[WALL_TOP] = 1'b1;
      end else if (ny > Y_MAX) begin
         cy_cl                = Y_MAX[COORD_W-1:0];
         vy_cl                = BOUNCE ? -vy : '0;
         wall_cl[WALL_BOTTOM] = 1'b1;
      end
   end

   always_ff @(posedge clk_25mHz or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         tick_q       <= 1'b0;
         tick_prev    <= 1'b0;
         ax_r         <= '0;
         ay_r         <= '0;
         vx           <= '0;
         vy           <= '0;
         nx           <= '0;
         ny           <= '0;
         center_x     <= COORD_W'(SCREEN_W / 2);
         center_y     <= COORD_W'(SCREEN_H / 2);
         pos_valid    <= 1'b0;
         wall_hit     <= '0;
         tick_overrun <= 1'b0;
      end else begin
         tick_q    <= bus.frame_tick;
         tick_prev <= tick_q;
         pos_valid <= 1'b0;
         // Edges arriving mid-frame are dropped, only flagged.
         if (tick_edge && state != ST_IDLE)
            tick_overrun <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (tick_edge)
                  state <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
               ax_r  <= tilt_x + btn_x;
               ay_r  <= tilt_y + btn_y;
               state <= ST_VEL;
            end
            ST_VEL: begin
               vx    <= bus.game_en ? vsat_x : '0;
               vy    <= bus.game_en ? vsat_y : '0;
               state <= ST_POS;
            end
            ST_POS: begin
               nx    <= $signed({2'b00, center_x}) + $signed({{(POS_W-VEL_W){vx[VEL_W-1]}}, vx});
               ny    <= $signed({2'b00, center_y}) + $signed({{(POS_W-VEL_W){vy[VEL_W-1]}}, vy});
               state <= ST_CLAMP;
            end
            ST_CLAMP: begin
               center_x  <= cx_cl;
               center_y  <= cy_cl;
               vx        <= vx_cl;
               vy        <= vy_cl;
               wall_hit  <= wall_cl;
               pos_valid <= 1'b1;
               state     <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.center_x     = center_x;
   assign bus.center_y     = center_y;
   assign bus.pos_valid    = pos_valid;
   assign bus.wall_hit     = wall_hit;
   assign bus.tick_overrun = tick_overrun;

endmodule

// File: tb/tb_box_motion.sv
// tb/tb_box_motion.sv - scoreboard bench for box_motion: per-frame model, latency, walls, overrun, reset
module tb_box_motion;
   import vga_pkg::*;

   localparam int ACCEL_SHIFT = 6;
   localparam int VMAX        = 8;
`ifdef BOX_MOTION_BOUNCE_EN
   localparam bit BOUNCE = 1'b1;
`else
   localparam bit BOUNCE = 1'b0;
`endif

   logic clk_25mHz = 1'b0;
   logic reset     = 1'b0;

   box_motion_if bus ();

   box_motion dut (
      .clk_25mHz (clk_25mHz),
      .reset     (reset),
      .bus       (bus)
   );

   always #20 clk_25mHz = ~clk_25mHz;

   int checks   = 0;
   int errors   = 0;
   int pv_count = 0;
   logic [23:0] exp_q[$];
   logic [23:0] mon_e;
   int m_vx, m_vy, m_cx, m_cy;
   logic [3:0] m_wall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      if (v > VMAX)  return VMAX;
      if (v < -VMAX) return -VMAX;
      return v;
   endfunction

   task automatic model_reset();
      m_vx = 0; m_vy = 0; m_cx = 320; m_cy = 240; m_wall = '0;
   endtask

   task automatic model_step();
      int ax, ay, nx, ny, sx, sy;
      sx = bus.accel_x >>> ACCEL_SHIFT;
      sy = bus.accel_y >>> ACCEL_SHIFT;
      ax = sat(sx) + int'(bus.BTNR) - int'(bus.BTNL);
      ay = sat(sy) + int'(bus.BTND) - int'(bus.BTNU);
      if (bus.game_en) begin
         m_vx = sat(m_vx + ax);
         m_vy = sat(m_vy + ay);
      end else begin
         m_vx = 0;
         m_vy = 0;
      end
      nx = m_cx + m_vx;
      ny = m_cy + m_vy;
      m_wall = '0;
      if (nx < HALF_SIZE) begin
         nx = HALF_SIZE; m_wall[1] = 1'b1; m_vx = BOUNCE ? -m_vx : 0;
      end else if (nx > SCREEN_W - 1 - HALF_SIZE) begin
         nx = SCREEN_W - 1 - HALF_SIZE; m_wall[0] = 1'b1; m_vx = BOUNCE ? -m_vx : 0;
      end
      if (ny < HALF_SIZE) begin
         ny = HALF_SIZE; m_wall[3] = 1'b1; m_vy = BOUNCE ? -m_vy : 0;
      end else if (ny > SCREEN_H - 1 - HALF_SIZE) begin
         ny = SCREEN_H - 1 - HALF_SIZE; m_wall[2] = 1'b1; m_vy = BOUNCE ? -m_vy : 0;
      end
      m_cx = nx;
      m_cy = ny;
      exp_q.push_back({m_cx[9:0], m_cy[9:0], m_wall});
   endtask

   always @(negedge clk_25mHz) begin
      if (reset && bus.pos_valid) begin
         pv_count++;
         if (exp_q.size() == 0) begin
            check("unexpected_pos_valid", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("center_x", 32'(bus.center_x), 32'(mon_e[23:14]));
            check("center_y", 32'(bus.center_y), 32'(mon_e[13:4]));
            check("wall_hit", 32'(bus.wall_hit), 32'(mon_e[3:0]));
         end
      end
   end

   task automatic run_frame();
      int n;
      bit seen;
      model_step();
      @(negedge clk_25mHz);
      bus.frame_tick = 1'b1;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk_25mHz);
         n++;
         if (n == 1) bus.frame_tick = 1'b0;
         if (bus.pos_valid) seen = 1'b1;
      end
      check("pos_valid_latency", 32'(n), 32'd6);
      @(negedge clk_25mHz);
   endtask

   task automatic apply_reset();
      @(negedge clk_25mHz);
      reset = 1'b0;
      exp_q.delete();
      model_reset();
      @(negedge clk_25mHz);
      reset = 1'b1;
      @(negedge clk_25mHz);
   endtask

   initial begin
      int n, pv0;
      bus.frame_tick = 1'b0;
      bus.accel_x = '0; bus.accel_y = '0;
      bus.BTNU = 1'b0; bus.BTND = 1'b0; bus.BTNL = 1'b0; bus.BTNR = 1'b0;
      bus.game_en = 1'b1;
      model_reset();
      repeat (3) @(negedge clk_25mHz);
      check("rst_center_x", 32'(bus.center_x), 32'd320);
      check("rst_center_y", 32'(bus.center_y), 32'd240);
      check("rst_pos_valid", 32'(bus.pos_valid), 32'd0);
      check("rst_wall_hit", 32'(bus.wall_hit), 32'd0);
      check("rst_overrun", 32'(bus.tick_overrun), 32'd0);
      reset = 1'b1;
      @(negedge clk_25mHz);

      repeat (3) run_frame();
      check("idle_pv_count", 32'(pv_count), 32'd3);
      check("idle_center_x", 32'(bus.center_x), 32'd320);

      apply_reset();
      bus.accel_x = 32'sd64;
      repeat (4) run_frame();
      check("tilt_center_x", 32'(bus.center_x), 32'd330);
      check("tilt_center_y", 32'(bus.center_y), 32'd240);
      bus.accel_x = '0;

      apply_reset();
      bus.BTNL = 1'b1;
      repeat (12) run_frame();
      check("btnl_center_x", 32'(bus.center_x), 32'd252);
      bus.BTNL = 1'b0;

      bus.game_en = 1'b0;
      bus.accel_x = -32'sd1000;
      run_frame();
      check("frozen_center_x", 32'(bus.center_x), 32'd252);
      bus.game_en = 1'b1;
      bus.accel_x = '0;

      apply_reset();
      bus.accel_y = 32'sh7FFF_FFFF;
      n = 0;
      while (bus.wall_hit == 4'b0000 && n < 40) begin
         run_frame();
         n++;
      end
      check("bottom_center_y", 32'(bus.center_y), 32'd454);
      check("bottom_wall_hit", 32'(bus.wall_hit), 32'b0100);
      repeat (5) @(negedge clk_25mHz);
      check("wall_hit_hold", 32'(bus.wall_hit), 32'b0100);
      run_frame();
      check("bottom_after_center_y", 32'(bus.center_y), 32'd454);
      bus.accel_y = '0;

      apply_reset();
      model_step();
      pv0 = pv_count;
      @(negedge clk_25mHz); bus.frame_tick = 1'b1;
      @(negedge clk_25mHz); bus.frame_tick = 1'b0;
      @(negedge clk_25mHz);
      @(negedge clk_25mHz); bus.frame_tick = 1'b1;
      @(negedge clk_25mHz); bus.frame_tick = 1'b0;
      repeat (15) @(negedge clk_25mHz);
      check("overrun_pv_count", 32'(pv_count - pv0), 32'd1);
      check("tick_overrun_set", 32'(bus.tick_overrun), 32'd1);
      run_frame();
      check("tick_overrun_sticky", 32'(bus.tick_overrun), 32'd1);

      apply_reset();
      check("overrun_cleared", 32'(bus.tick_overrun), 32'd0);
      bus.accel_x = 32'sd64;
      repeat (3) run_frame();
      check("premid_center_x", 32'(bus.center_x), 32'd326);
      @(negedge clk_25mHz); bus.frame_tick = 1'b1;
      @(negedge clk_25mHz); bus.frame_tick = 1'b0;
      repeat (3) @(negedge clk_25mHz);
      reset = 1'b0;
      #1;
      check("mid_rst_center_x", 32'(bus.center_x), 32'd320);
      check("mid_rst_center_y", 32'(bus.center_y), 32'd240);
      check("mid_rst_pos_valid", 32'(bus.pos_valid), 32'd0);
      exp_q.delete();
      model_reset();
      @(negedge clk_25mHz);
      reset = 1'b1;
      @(negedge clk_25mHz);
      run_frame();
      check("post_rst_center_x", 32'(bus.center_x), 32'd321);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
